// File: rtl/dma_line_writer.sv
// dma_line_writer
//   Bus-mastering DMA engine that moves a block of words from the external
//   device into memory port 2. Each memory write carries one line of
//   LINE_WORDS words. The engine requests the bus with br and waits for bg
//   before it drives a write. The device uses dev_offset to select the line
//   it places on the shared data bus. When the block is finished the engine
//   releases the bus and pulses done_intr for one cycle.
//
//   Build option: DMA_CYCLE_STEAL_EN
//     undefined (default) - the bus is held for the whole block.
//     defined             - the bus is released between lines, so the cpu
//                           can run between them.
//
// Ports
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle command pulse
//   start_addr  in   destination base word address
//   length      in   number of words to move (rounded down to a line multiple)
//   bg          in   bus grant
//   write_ack   in   memory write acknowledge (one-cycle pulse)
//   br          out  bus request
//   m_write     out  memory write strobe
//   m_address   out  memory word address
//   dev_offset  out  word offset of the current line in the device buffer
//   busy        out  high whenever the engine is not idle
//   done_intr   out  one-cycle completion pulse
//
// State table
//   state       | meaning
//   S_IDLE      | waiting for start
//   S_REQ       | br asserted, waiting for bg
//   S_XFER      | m_write held until write_ack
//   S_GAP       | (cycle steal) br dropped between lines, waiting for bg low
//   S_GAP_IDLE  | (cycle steal) one idle cycle before the next request
//   S_RELEASE   | br dropped, waiting for bg low
//   S_DONE      | done_intr pulse cycle
module dma_line_writer #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] start_addr,
  input  logic [WORD_SIZE-1:0] length,
  input  logic                 bg,
  input  logic                 write_ack,
  output logic                 br,
  output logic                 m_write,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] dev_offset,
  output logic                 busy,
  output logic                 done_intr
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_XFER, S_GAP, S_GAP_IDLE, S_RELEASE, S_DONE
  } state_t;

  localparam logic [WORD_SIZE-1:0] STEP     = WORD_SIZE'(LINE_WORDS);
  localparam logic [WORD_SIZE-1:0] LEN_MASK = ~(WORD_SIZE'(LINE_WORDS - 1));

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] len_q, len_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [WORD_SIZE-1:0] off_q, off_d;
  logic [WORD_SIZE-1:0] off_inc;
  logic [WORD_SIZE-1:0] len_start;
  logic                 br_d, m_write_d, busy_d, done_d;
  logic [WORD_SIZE-1:0] m_address_d, dev_offset_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      base_q     <= '0;
      off_q      <= '0;
      br         <= 1'b0;
      m_write    <= 1'b0;
      m_address  <= '0;
      dev_offset <= '0;
      busy       <= 1'b0;
      done_intr  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      base_q     <= base_d;
      off_q      <= off_d;
      br         <= br_d;
      m_write    <= m_write_d;
      m_address  <= m_address_d;
      dev_offset <= dev_offset_d;
      busy       <= busy_d;
      done_intr  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    base_d       = base_q;
    off_d        = off_q;
    br_d         = br;
    m_write_d    = m_write;
    m_address_d  = m_address;
    dev_offset_d = dev_offset;
    busy_d       = busy;
    done_d       = 1'b0;
    off_inc      = off_q + STEP;
    len_start    = length & LEN_MASK;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = len_start;
          base_d = start_addr;
          off_d  = '0;
          busy_d = 1'b1;
          // A block shorter than one line completes without touching the bus.
          if (len_start == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_REQ;
            br_d    = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bg) begin
          state_d      = S_XFER;
          m_write_d    = 1'b1;
          m_address_d  = base_q + off_q;
          dev_offset_d = off_q;
        end
      end
      S_XFER: begin
        // An ack on the same edge that grant falls still completes the line.
        if (write_ack) begin
          m_write_d = 1'b0;
          off_d     = off_inc;
          if (off_inc == len_q) begin
            state_d = S_RELEASE;
            br_d    = 1'b0;
          end else begin
`ifdef DMA_CYCLE_STEAL_EN
            state_d = S_GAP;
            br_d    = 1'b0;
`else
            state_d = S_REQ;
`endif
          end
        end else if (!bg) begin
          // Grant lost before the ack: retry the same line after regrant.
          m_write_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_GAP: begin
        if (!bg) state_d = S_GAP_IDLE;
      end
      S_GAP_IDLE: begin
        state_d = S_REQ;
        br_d    = 1'b1;
      end
      S_RELEASE: begin
        if (!bg) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_line_writer.sv
module tb_dma_line_writer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] length;
  logic        bg;
  logic        write_ack;
  logic        br;
  logic        m_write;
  logic [15:0] m_address;
  logic [15:0] dev_offset;
  logic        busy;
  logic        done_intr;

  dma_line_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .bg         (bg),
    .write_ack  (write_ack),
    .br         (br),
    .m_write    (m_write),
    .m_address  (m_address),
    .dev_offset (dev_offset),
    .busy       (busy),
    .done_intr  (done_intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] off;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done  = 0;
  int   done_seen = 0;
  int   checks    = 0;
  int   errors    = 0;
  int   br_rises  = 0;
  int   mw_rises  = 0;

  // cpu / memory behaviour knobs
  int gnt_delay = 1, ack_delay = 2, rel_delay = 0;
  int drop_line = -1;
  bit dropped   = 1'b0;
  int gnt_wait = 0, rel_wait = 0, ack_cnt = 0, drop_cnt = 0;

`ifdef DMA_CYCLE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // cpu arbiter and memory acknowledge model; drives just after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (!reset_n) begin
      bg = 1'b0; write_ack = 1'b0;
      gnt_wait = 0; rel_wait = 0; ack_cnt = 0; drop_cnt = 0;
    end else if (m_write && !dropped && drop_line >= 0 &&
                 dev_offset == 16'(drop_line * 4) && !write_ack) begin
      bg = 1'b0; drop_cnt = 2; dropped = 1'b1;
      write_ack = 1'b0; ack_cnt = 0;
    end else begin
      if (drop_cnt > 0) drop_cnt--;
      else if (br) begin
        rel_wait = 0;
        if (!bg) begin
          if (gnt_wait >= gnt_delay) begin bg = 1'b1; gnt_wait = 0; end
          else gnt_wait++;
        end
      end else if (bg) begin
        if (rel_wait >= rel_delay) begin bg = 1'b0; rel_wait = 0; end
        else rel_wait++;
      end else gnt_wait = 0;

      if (write_ack) begin write_ack = 1'b0; ack_cnt = 0; end
      else if (m_write) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) write_ack = 1'b1;
      end else ack_cnt = 0;
    end
  end

  // monitor: compares completed writes and done pulses against the scoreboard
  logic bg_prev = 1'b0, mw_prev = 1'b0, br_prev = 1'b0, done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (m_write) check("grant_before_write", 64'(bg_prev), 64'd1);
      if (m_write && !mw_prev) mw_rises++;
      if (br && !br_prev) br_rises++;
      if (m_write && write_ack) begin
        check("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("write_addr", 64'(m_address), 64'(e.addr));
          check("write_offset", 64'(dev_offset), 64'(e.off));
        end
      end
      if (done_intr) begin
        done_seen++;
        check("done_expected", 64'(exp_done > 0), 64'd1);
        check("done_single_cycle", 64'(done_prev), 64'd0);
        check("lines_left_at_done", 64'(exp_q.size()), 64'd0);
        if (exp_done > 0) exp_done--;
      end
    end
    bg_prev   = bg;
    mw_prev   = m_write;
    br_prev   = br;
    done_prev = done_intr;
  end

  task automatic push_model(input logic [15:0] a, input logic [15:0] l);
    int n;
    exp_t e;
    n = int'(l) / 4;
    for (int i = 0; i < n; i++) begin
      e.addr = a + 16'(4 * i);
      e.off  = 16'(4 * i);
      exp_q.push_back(e);
    end
    exp_done++;
  endtask

  task automatic do_xfer(input logic [15:0] a, input logic [15:0] l, input int drop,
                         input bit poke, input int gd, input int ad, input int rd);
    int n, d0, c;
    n = int'(l) / 4;
    gnt_delay = gd; ack_delay = ad; rel_delay = rd;
    drop_line = drop; dropped = 1'b0;
    br_rises = 0; mw_rises = 0;
    push_model(a, l);
    d0 = done_seen;
    @(posedge clk); #1;
    start_addr = a; length = l; start = 1'b1;
    c = 0;
    while (c < 3000 && done_seen == d0) begin
      @(posedge clk); #1;
      start      = 1'b0;
      start_addr = 16'($urandom);
      length     = 16'($urandom_range(4, 40));
      if (poke && (c == 3 || done_intr)) start = 1'b1;
      c++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("done_count", 64'(done_seen - d0), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    check("br_after_done", 64'(br), 64'd0);
    check("lines_remaining", 64'(exp_q.size()), 64'd0);
    check("br_rises", 64'(br_rises), 64'((n == 0) ? 0 : (STEAL ? n : 1)));
    check("write_issues", 64'(mw_rises), 64'(n + ((drop >= 0 && n > 0) ? 1 : 0)));
  endtask

  initial begin
    int c;
    reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    bg = 1'b0; write_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {br, m_write, busy, done_intr, m_address, dev_offset}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    do_xfer(16'h0017, 16'd12, -1, 1'b0, 1, 2, 0);
    do_xfer(16'h0100, 16'h000E, -1, 1'b0, 1, 2, 1);
    do_xfer(16'h0200, 16'h0003, -1, 1'b1, 1, 2, 0);
    do_xfer(16'hFFFC, 16'd8, -1, 1'b0, 0, 1, 0);
    do_xfer(16'h0300, 16'd12, 1, 1'b0, 1, 2, 1);

    // reset during line 2, then a full fresh transfer
    gnt_delay = 1; ack_delay = 2; rel_delay = 0; drop_line = -1;
    push_model(16'h0400, 16'd12);
    @(posedge clk); #1;
    start_addr = 16'h0400; length = 16'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (c < 500 && !(m_write && dev_offset == 16'd4)) begin
      @(posedge clk); #1;
      c++;
    end
    check("reached_line2", 64'(m_write && dev_offset == 16'd4), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midxfer_reset_outputs", {br, m_write, busy, done_intr, m_address, dev_offset}, 64'd0);
    exp_q.delete();
    exp_done = 0;
    c = done_seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_seen - c), 64'd0);
    do_xfer(16'h0400, 16'd12, -1, 1'b0, 1, 2, 0);

    for (int t = 0; t < 10; t++) begin
      logic [15:0] ra, rl;
      int nl, rdrop;
      ra = 16'($urandom);
      rl = 16'($urandom_range(0, 40));
      nl = int'(rl) / 4;
      rdrop = (nl > 0 && ($urandom % 3) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
      do_xfer(ra, rl, rdrop, 1'($urandom % 2), int'($urandom_range(0, 2)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
